// File: rtl/acc_drain_if.sv
// Partial-sum, accumulator and result port bundle for acc_drain.
// valid/ready: a word transfers on a rising edge where both are high; the producer holds valid and data stable until then.
interface acc_drain_if #(
  parameter int ACC_W  = 28,
  parameter int PSUM_W = 20,
  parameter int OUT_W  = 16
);
  logic [PSUM_W-1:0] psum_in;
  logic              psum_valid;
  logic              psum_ready;
  logic [PSUM_W-1:0] psum_out;
  logic              acc_clear;
  logic [ACC_W-1:0]  acc_value;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  psum_in, psum_valid, acc_value, out_ready,
    output psum_ready, psum_out, acc_clear, out_data, out_valid
  );

  modport master (
    output psum_in, psum_valid, acc_value, out_ready,
    input  psum_ready, psum_out, acc_clear, out_data, out_valid
  );
endinterface

// File: rtl/acc_drain.sv
// Accumulator window controller: gates partial sums for a programmed window,
// captures and requantizes the total, and presents it on a valid/ready port.
module acc_drain #(
  parameter int ACC_W  = 28,
  parameter int PSUM_W = 20,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  acc_drain_if.slave       io,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_ACCUM   = 2'd1,
    S_CAPTURE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q;
  logic [4:0]       shift_q;
  logic             relu_q;
  logic [OUT_W-1:0] out_q;
  logic             accept;
  logic             latch_cfg;

  logic signed [ACC_W:0] ext, rounded, shifted, clamped;
  logic        [ACC_W:0] rnd;
  logic [OUT_W-1:0]      q_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    latch_cfg     = 1'b0;
    accept        = 1'b0;
    io.psum_ready = 1'b0;
    io.acc_clear  = 1'b0;
    io.out_valid  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        io.acc_clear = 1'b1;
        latch_cfg    = 1'b1;
        state_d      = S_ACCUM;
      end
      S_ACCUM: begin
        io.psum_ready = 1'b1;
        accept        = io.psum_valid;
        if (accept) begin
          if (cnt_q == len_q - 1'b1) begin
            cnt_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        // Accumulator clears on the same edge that captures its total.
        io.acc_clear = 1'b1;
        state_d      = S_OUTPUT;
      end
      S_OUTPUT: begin
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          latch_cfg = 1'b1;
          state_d   = S_ACCUM;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign io.psum_out = accept ? io.psum_in : '0;
  assign io.out_data = out_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= CNT_W'(1);
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (latch_cfg) begin
      len_q   <= (cfg_len == '0) ? CNT_W'(1) : cfg_len;
      shift_q <= cfg_shift;
      relu_q  <= cfg_relu;
    end
  end

  // One guard bit above the total keeps the rounding add from overflowing.
  always_comb begin
    ext     = {io.acc_value[ACC_W-1], io.acc_value};
    rnd     = (shift_q == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift_q - 5'd1));
    rounded = ext + signed'(rnd);
    shifted = rounded >>> shift_q;
    clamped = (relu_q && shifted[ACC_W]) ? '0 : shifted;
    if (clamped > SAT_MAX) begin
      q_next = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (clamped < SAT_MIN) begin
      q_next = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      q_next = clamped[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else if (state_q == S_CAPTURE) begin
      out_q <= q_next;
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain with a behavioural accumulator on acc_value.
module tb_acc_drain;

  typedef struct packed {
    logic [7:0]       len;
    logic [4:0]       shift;
    logic             relu;
    logic [2:0]       n;
    logic [3:0][19:0] p;
    logic [15:0]      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cfg_len = 8'd0;
  logic [4:0]  cfg_shift = 5'd0;
  logic        cfg_relu = 1'b0;
  logic [1:0]  dbg_state;
  logic signed [27:0] acc_model = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [15:0] exp_q[$];
  vec_t vecs[13];

  acc_drain_if #(.ACC_W(28), .PSUM_W(20), .OUT_W(16)) io ();

  acc_drain dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .io        (io),
    .dbg_state (dbg_state)
  );

  // Clock, cycle counter and the external accumulator the block controls.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (io.acc_clear) acc_model <= '0;
    else acc_model <= acc_model + {{8{io.psum_out[19]}}, io.psum_out};
  end
  assign io.acc_value = acc_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int len, input int shift, input int relu, input int n,
                              input int a, input int b, input int c, input int d, input int e);
    vec_t v;
    v.len = 8'(len);
    v.shift = 5'(shift);
    v.relu = 1'(relu);
    v.n = 3'(n);
    v.p[0] = 20'(a);
    v.p[1] = 20'(b);
    v.p[2] = 20'(c);
    v.p[3] = 20'(d);
    v.exp = 16'(e);
    return v;
  endfunction

  task automatic set_cfg(input int len, input int shift, input int relu);
    cfg_len = 8'(len);
    cfg_shift = 5'(shift);
    cfg_relu = 1'(relu);
  endtask

  task automatic send(input logic [19:0] v);
    bit done = 1'b0;
    io.psum_in = v;
    io.psum_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (io.psum_ready) begin
        check("psum_out_pass", 32'(io.psum_out), 32'(v));
        last_acc = cyc;
        done = 1'b1;
      end else begin
        check("psum_out_blocked", 32'(io.psum_out), 32'd0);
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    io.psum_valid = 1'b0;
  endtask

  task automatic collect(input int stall, input int nlen, input int nshift, input int nrelu);
    bit seen = 1'b0;
    logic [15:0] e;
    @(negedge clk);
    check("capture_clear", 32'(io.acc_clear), 32'd1);
    check("capture_ready", 32'(io.psum_ready), 32'd0);
    check("capture_valid", 32'(io.out_valid), 32'd0);
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (io.out_valid) seen = 1'b1;
    end
    if (!seen) begin
      check("out_timeout", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("latency", 32'(cyc - last_acc), 32'd2);
      check("out_data", 32'(io.out_data), 32'(e));
      check("out_clear_low", 32'(io.acc_clear), 32'd0);
      for (int k = 0; k < stall; k++) begin
        io.psum_in = 20'd55;
        io.psum_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_valid", 32'(io.out_valid), 32'd1);
        check("stall_data", 32'(io.out_data), 32'(e));
        check("stall_ready", 32'(io.psum_ready), 32'd0);
        check("stall_psum_out", 32'(io.psum_out), 32'd0);
      end
      io.psum_valid = 1'b0;
    end
    set_cfg(nlen, nshift, nrelu);
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_valid", 32'(io.out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = mk(4, 0, 0, 4, 10, 20, 30, 40, 100);
    vecs[1]  = mk(1, 2, 0, 1, 10, 0, 0, 0, 3);
    vecs[2]  = mk(1, 2, 0, 1, -6, 0, 0, 0, -1);
    vecs[3]  = mk(1, 2, 1, 1, -6, 0, 0, 0, 0);
    vecs[4]  = mk(2, 0, 0, 2, 'h7FFFF, 'h7FFFF, 0, 0, 32767);
    vecs[5]  = mk(2, 0, 0, 2, 'h80000, 'h80000, 0, 0, -32768);
    vecs[6]  = mk(0, 0, 0, 1, 5, 0, 0, 0, 5);
    vecs[7]  = mk(3, 1, 0, 3, 7, 8, -2, 0, 7);
    vecs[8]  = mk(2, 4, 0, 2, 100, 23, 0, 0, 8);
    vecs[9]  = mk(1, 4, 0, 1, -25, 0, 0, 0, -2);
    vecs[10] = mk(2, 0, 0, 2, 32767, 1, 0, 0, 32767);
    vecs[11] = mk(2, 0, 0, 2, -32768, -1, 0, 0, -32768);
    vecs[12] = mk(1, 1, 1, 1, 9, 0, 0, 0, 5);

    io.psum_in = '0;
    io.psum_valid = 1'b0;
    io.out_ready = 1'b0;
    set_cfg(int'(vecs[0].len), int'(vecs[0].shift), int'(vecs[0].relu));

    // Reset state.
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_out_data", 32'(io.out_data), 32'd0);
    check("rst_psum_ready", 32'(io.psum_ready), 32'd0);
    check("rst_acc_clear", 32'(io.acc_clear), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    io.psum_in = 20'd77;
    io.psum_valid = 1'b1;
    @(negedge clk);
    check("clear_acc_clear", 32'(io.acc_clear), 32'd1);
    check("clear_psum_ready", 32'(io.psum_ready), 32'd0);
    check("clear_psum_out", 32'(io.psum_out), 32'd0);
    @(posedge clk); #1;
    io.psum_valid = 1'b0;

    // Table of single windows; each handshake loads the next window's config.
    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      for (int j = 0; j < int'(v.n); j++) send(v.p[j]);
      exp_q.push_back(v.exp);
      if (i < 12) collect(0, int'(vecs[i+1].len), int'(vecs[i+1].shift), int'(vecs[i+1].relu));
      else collect(0, 3, 0, 0);
    end

    // len=3 with idle gaps: idle cycles neither count nor pass data.
    send(20'd5);
    io.psum_in = 20'd99;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("gap_psum_out", 32'(io.psum_out), 32'd0);
      check("gap_ready", 32'(io.psum_ready), 32'd1);
      check("gap_valid", 32'(io.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send(20'd6);
    send(20'd7);
    exp_q.push_back(16'd18);
    collect(0, 2, 0, 0);

    // Output stall for 5 cycles with psum_valid pressing.
    send(20'd3);
    send(20'd4);
    exp_q.push_back(16'd7);
    collect(5, 4, 0, 0);

    // Reset after 2 of 4 samples, then a fresh window.
    send(20'd7);
    send(20'd9);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(io.out_valid), 32'd0);
    check("midrst_ready", 32'(io.psum_ready), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_clear", 32'(io.acc_clear), 32'd1);
    check("postrst_valid", 32'(io.out_valid), 32'd0);
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) send(20'd1);
    exp_q.push_back(16'd4);
    collect(0, 1, 0, 0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
